// File: rtl/bpsk_frame_gen_if.sv
// bpsk_frame_gen_if
//   Symbol-rate control, payload handshake and framed serial output of the
//   BPSK frame generator.
//   master : frame source / sequencer side (drives sym_en, start, din_*)
//   slave  : bpsk_frame_gen itself (drives din_ready and the framed outputs)
//   Signals:
//     sym_en      symbol strobe, one clock per bit period
//     start       frame request pulse
//     din_valid   payload bit available
//     din_bit     payload bit
//     din_ready   payload bit consumed this cycle (combinational)
//     bit_out     framed serial bit, held between strobes
//     bit_valid   bit_out carries a preamble/payload symbol
//     in_preamble bit_out carries a Barker chip
//     busy        frame in progress
//     underrun    one-cycle pulse: payload symbol had no valid data
//     frame_done  one-cycle pulse on the first cycle back in IDLE
interface bpsk_frame_gen_if;
  logic sym_en;
  logic start;
  logic din_valid;
  logic din_bit;
  logic din_ready;
  logic bit_out;
  logic bit_valid;
  logic in_preamble;
  logic busy;
  logic underrun;
  logic frame_done;

  modport master (
    output sym_en, start, din_valid, din_bit,
    input  din_ready, bit_out, bit_valid, in_preamble, busy, underrun, frame_done
  );

  modport slave (
    input  sym_en, start, din_valid, din_bit,
    output din_ready, bit_out, bit_valid, in_preamble, busy, underrun, frame_done
  );
endinterface

// File: rtl/bpsk_frame_gen.sv
// bpsk_frame_gen
//   Framing stage of the BPSK transmitter. Each frame is a 13-chip Barker
//   preamble (MSB first), PAYLOAD_LEN bits pulled over a valid/ready
//   handshake, then GAP_LEN idle symbols. One bit is emitted per sym_en
//   strobe; all outputs except din_ready are registered and appear the
//   cycle after the strobe.
//   Ports:
//     clk_sig    system clock
//     reset_sig  synchronous, active-high reset
//     bus        bpsk_frame_gen_if.slave (strobe, start, payload handshake,
//                framed outputs and status pulses)
//   Optional feature (macro BPSK_DIFF_ENC_EN): differential encoding of the
//   preamble and payload, bit_out = raw ^ previous emitted bit, with the
//   reference cleared at frame start. Gap symbols are 0 and leave the
//   reference untouched. Without the macro bit_out is the raw bit.
module bpsk_frame_gen #(
  parameter int          PAYLOAD_LEN = 64,
  parameter int          GAP_LEN     = 4,
  parameter logic [12:0] BARKER      = 13'b1111100110101
) (
  input logic              clk_sig,
  input logic              reset_sig,
  bpsk_frame_gen_if.slave  bus
);

  localparam int PW = (PAYLOAD_LEN > 0) ? $clog2(PAYLOAD_LEN + 1) : 1;
  localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
  localparam logic [PW-1:0] PAY_LAST = PW'(PAYLOAD_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY, S_GAP} state_t;

  state_t         r_state;
  logic           r_pending;
  logic [3:0]     r_chip_cnt;
  logic [PW-1:0]  r_pay_cnt;
  logic [GW-1:0]  r_gap_cnt;
  logic           r_bit_out;
  logic           r_bit_valid;
  logic           r_in_pre;
  logic           r_busy;
  logic           r_underrun;
  logic           r_frame_done;

  logic           w_raw;
  logic           w_enc;

  // Raw symbol for the strobe being processed. In IDLE it is the first chip,
  // only used when a frame actually starts.
  always_comb begin
    w_raw = 1'b0;
    case (r_state)
      S_IDLE:  w_raw = BARKER[12];
      S_PRE:   w_raw = BARKER[4'd12 - r_chip_cnt];
      S_PAY:   w_raw = bus.din_valid & bus.din_bit;
      default: w_raw = 1'b0;
    endcase
  end

`ifdef BPSK_DIFF_ENC_EN
  logic r_ref;
  // At frame start the reference is logically 0, so the first chip passes raw.
  assign w_enc = (r_state == S_IDLE) ? w_raw : (w_raw ^ r_ref);

  always_ff @(posedge clk_sig) begin
    if (reset_sig) begin
      r_ref <= 1'b0;
    end else if (bus.sym_en && (r_state == S_PRE || r_state == S_PAY ||
                 (r_state == S_IDLE && (r_pending || bus.start)))) begin
      r_ref <= w_enc;
    end
  end
`else
  assign w_enc = w_raw;
`endif

  assign bus.din_ready   = (r_state == S_PAY) & bus.sym_en;
  assign bus.bit_out     = r_bit_out;
  assign bus.bit_valid   = r_bit_valid;
  assign bus.in_preamble = r_in_pre;
  assign bus.busy        = r_busy;
  assign bus.underrun    = r_underrun;
  assign bus.frame_done  = r_frame_done;

  always_ff @(posedge clk_sig) begin
    if (reset_sig) begin
      r_state      <= S_IDLE;
      r_pending    <= 1'b0;
      r_chip_cnt   <= '0;
      r_pay_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_in_pre     <= 1'b0;
      r_busy       <= 1'b0;
      r_underrun   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_underrun   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.sym_en) begin
            if (r_pending || bus.start) begin
              r_state     <= S_PRE;
              r_pending   <= 1'b0;
              r_chip_cnt  <= 4'd1;
              r_bit_out   <= w_enc;
              r_bit_valid <= 1'b1;
              r_in_pre    <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_bit_out   <= 1'b0;
              r_bit_valid <= 1'b0;
              r_in_pre    <= 1'b0;
            end
          end else if (bus.start) begin
            r_pending <= 1'b1;
          end
        end
        S_PRE: begin
          if (bus.sym_en) begin
            r_bit_out  <= w_enc;
            r_chip_cnt <= r_chip_cnt + 4'd1;
            // chip_cnt==12 means the 13th (last) chip is going out now
            if (r_chip_cnt == 4'd12) begin
              r_state   <= S_PAY;
              r_pay_cnt <= '0;
            end
          end
        end
        S_PAY: begin
          if (bus.sym_en) begin
            r_bit_out   <= w_enc;
            r_bit_valid <= 1'b1;
            r_in_pre    <= 1'b0;
            r_underrun  <= ~bus.din_valid;
            r_pay_cnt   <= r_pay_cnt + PW'(1);
            if (r_pay_cnt == PAY_LAST) begin
              if (GAP_LEN == 0) begin
                r_state      <= S_IDLE;
                r_busy       <= 1'b0;
                r_frame_done <= 1'b1;
              end else begin
                r_state   <= S_GAP;
                r_gap_cnt <= '0;
              end
            end
          end
        end
        S_GAP: begin
          if (bus.sym_en) begin
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_in_pre    <= 1'b0;
            r_gap_cnt   <= r_gap_cnt + GW'(1);
            if (r_gap_cnt == GAP_LAST) begin
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_frame_gen.sv
// tb_bpsk_frame_gen
//   Drives two generators from one stimulus stream: dut0 with PAYLOAD_LEN=8,
//   GAP_LEN=2 and dut1 with GAP_LEN=0. A vector table covers two full frames
//   (clean payload, then an underrun plus an ignored mid-frame start),
//   followed by hand-written sequences for same-cycle start, mid-frame reset
//   and back-to-back frames without a gap.
module tb_bpsk_frame_gen;

`ifdef BPSK_DIFF_ENC_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  logic clk;
  logic rst;
  bpsk_frame_gen_if bi0 ();
  bpsk_frame_gen_if bi1 ();

  assign bi1.sym_en    = bi0.sym_en;
  assign bi1.start     = bi0.start;
  assign bi1.din_valid = bi0.din_valid;
  assign bi1.din_bit   = bi0.din_bit;

  bpsk_frame_gen #(.PAYLOAD_LEN(8), .GAP_LEN(2)) dut0 (
    .clk_sig(clk), .reset_sig(rst), .bus(bi0));
  bpsk_frame_gen #(.PAYLOAD_LEN(8), .GAP_LEN(0)) dut1 (
    .clk_sig(clk), .reset_sig(rst), .bus(bi1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic st, dv, db;
    logic eb, ev, ep, ebusy, eun, edone;
    logic edone1, ebusy1;
  } vec_t;

  vec_t        vecs[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          acc     = 0;
  int          bad_rdy = 0;
  logic        m_ref;
  logic [12:0] bk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected emitted bit: raw, optionally differentially encoded.
  function automatic logic menc(input logic raw);
    logic e;
    e = raw ^ (DIFF & m_ref);
    m_ref = e;
    return e;
  endfunction

  // One symbol period (10 clocks): optional start pulse early in the period,
  // then a one-clock sym_en; returns just after the strobe edge, at a negedge.
  task automatic sym(input logic st, input logic dv, input logic db);
    @(negedge clk); bi0.start = st;
    @(negedge clk); bi0.start = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (bi0.din_ready) bad_rdy++;
    end
    bi0.din_valid = dv; bi0.din_bit = db; bi0.sym_en = 1'b1;
    #1;
    if (bi0.din_ready && dv) acc++;
    @(negedge clk); bi0.sym_en = 1'b0;
  endtask

  function automatic void add_frame(input logic [7:0] pay, input logic [7:0] pv, input int mid_start);
    vec_t v;
    m_ref = 1'b0;
    for (int i = 0; i < 13; i++) begin
      v = '{default: 1'b0};
      v.st = (i == 0); v.dv = 1'b1;
      v.eb = menc(bk[12-i]); v.ev = 1'b1; v.ep = 1'b1;
      v.ebusy = 1'b1; v.ebusy1 = 1'b1;
      vecs.push_back(v);
    end
    for (int j = 0; j < 8; j++) begin
      v = '{default: 1'b0};
      v.st = (j == mid_start); v.dv = pv[7-j]; v.db = pay[7-j];
      v.eb = menc(pv[7-j] & pay[7-j]); v.ev = 1'b1;
      v.ebusy = 1'b1; v.eun = ~pv[7-j];
      v.edone1 = (j == 7); v.ebusy1 = (j != 7);
      vecs.push_back(v);
    end
    for (int g = 0; g < 2; g++) begin
      v = '{default: 1'b0};
      v.ebusy = (g == 0); v.edone = (g == 1);
      vecs.push_back(v);
    end
  endfunction

  initial begin
    vec_t v;
    logic saw;
    bk = 13'b1111100110101;
    add_frame(8'b10110010, 8'hFF, -1);
    add_frame(8'b01101101, 8'b11011111, 4);
    for (int k = 0; k < 3; k++) begin
      v = '{default: 1'b0};
      v.dv = 1'b1;
      vecs.push_back(v);
    end

    rst = 1'b1;
    bi0.sym_en = 1'b0; bi0.start = 1'b0; bi0.din_valid = 1'b0; bi0.din_bit = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset bit_out",     bi0.bit_out,     1'b0);
    chk("reset bit_valid",   bi0.bit_valid,   1'b0);
    chk("reset in_preamble", bi0.in_preamble, 1'b0);
    chk("reset busy",        bi0.busy,        1'b0);
    chk("reset underrun",    bi0.underrun,    1'b0);
    chk("reset frame_done",  bi0.frame_done,  1'b0);
    chk("reset din_ready",   bi0.din_ready,   1'b0);

    // Table: frame 1 clean, frame 2 underrun on payload bit 3 + ignored start
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (i == 0 || i == 23) acc = 0;
      sym(v.st, v.dv, v.db);
      chk($sformatf("row%0d bit_out", i),     bi0.bit_out,     v.eb);
      chk($sformatf("row%0d bit_valid", i),   bi0.bit_valid,   v.ev);
      chk($sformatf("row%0d in_preamble", i), bi0.in_preamble, v.ep);
      chk($sformatf("row%0d busy", i),        bi0.busy,        v.ebusy);
      chk($sformatf("row%0d underrun", i),    bi0.underrun,    v.eun);
      chk($sformatf("row%0d frame_done", i),  bi0.frame_done,  v.edone);
      chk($sformatf("row%0d g0 frame_done", i), bi1.frame_done, v.edone1);
      chk($sformatf("row%0d g0 busy", i),       bi1.busy,       v.ebusy1);
      if (v.eun) begin
        @(negedge clk);
        chk($sformatf("row%0d underrun pulse width", i), bi0.underrun, 1'b0);
      end
      if (v.edone) begin
        @(negedge clk);
        chk($sformatf("row%0d frame_done pulse width", i), bi0.frame_done, 1'b0);
      end
      if (i == 22) chk("frame1 accepted bits", acc, 8);
      if (i == 45) chk("frame2 accepted bits", acc, 7);
    end
    chk("no accepts while idle", acc, 7);
    chk("din_ready without strobe", bad_rdy, 0);

    // start coincident with sym_en in IDLE
    repeat (9) @(negedge clk);
    bi0.start = 1'b1; bi0.sym_en = 1'b1;
    @(negedge clk);
    bi0.start = 1'b0; bi0.sym_en = 1'b0;
    m_ref = 1'b0;
    chk("same-cycle start bit_out", bi0.bit_out, menc(bk[12]));
    chk("same-cycle start in_preamble", bi0.in_preamble, 1'b1);
    chk("same-cycle start busy", bi0.busy, 1'b1);
    for (int i = 1; i < 13; i++) begin
      sym(1'b0, 1'b0, 1'b0);
      chk($sformatf("sc chip%0d", i), bi0.bit_out, menc(bk[12-i]));
    end
    for (int j = 0; j < 4; j++) begin
      sym(1'b0, 1'b1, 1'b1);
      chk($sformatf("sc pay%0d", j), bi0.bit_out, menc(1'b1));
    end

    // reset while payload bit 4 is on the line
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset bit_out",     bi0.bit_out,     1'b0);
    chk("midreset bit_valid",   bi0.bit_valid,   1'b0);
    chk("midreset in_preamble", bi0.in_preamble, 1'b0);
    chk("midreset busy",        bi0.busy,        1'b0);
    chk("midreset frame_done",  bi0.frame_done,  1'b0);
    saw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      sym(1'b0, 1'b1, 1'b1);
      if (bi0.frame_done || bi0.busy) saw = 1'b1;
    end
    chk("no frame_done after reset", saw, 1'b0);
    m_ref = 1'b0;
    for (int i = 0; i < 13; i++) begin
      sym(i == 0, 1'b1, 1'b0);
      chk($sformatf("post-reset chip%0d", i), bi0.bit_out, menc(bk[12-i]));
      chk($sformatf("post-reset pre%0d", i), bi0.in_preamble, 1'b1);
    end
    sym(1'b0, 1'b1, 1'b1);
    chk("post-reset first payload pre", bi0.in_preamble, 1'b0);

    // GAP_LEN=0 instance: done after 8th payload strobe, then back-to-back
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 21; i++) sym(i == 0, 1'b1, 1'b1);
    chk("g0 frame_done after last payload", bi1.frame_done, 1'b1);
    chk("g0 busy after last payload", bi1.busy, 1'b0);
    chk("g2 still busy", bi0.busy, 1'b1);
    @(negedge clk);
    chk("g0 frame_done pulse width", bi1.frame_done, 1'b0);
    m_ref = 1'b0;
    sym(1'b1, 1'b0, 1'b0);
    chk("b2b busy", bi1.busy, 1'b1);
    chk("b2b first chip", bi1.bit_out, menc(bk[12]));
    chk("b2b in_preamble", bi1.in_preamble, 1'b1);
    chk("g2 gap bit_valid", bi0.bit_valid, 1'b0);
    sym(1'b0, 1'b0, 1'b0);
    chk("b2b second chip", bi1.bit_out, menc(bk[11]));
    chk("g2 frame_done", bi0.frame_done, 1'b1);
    sym(1'b0, 1'b0, 1'b0);
    chk("g2 start in gap not queued", bi0.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
